// File: rtl/lcd_ctrl.sv
// HD44780-style character-LCD write sequencer: turns a strobed command/data byte from the core's
// LCD I/O register into RS/DATA/EN bus timing plus the execution wait, with a one-entry request buffer.
module lcd_ctrl #(
  parameter int SETUP_CYC = 2,
  parameter int EN_CYC    = 12,
  parameter int HOLD_CYC  = 2,
  parameter int EXEC_CYC  = 2500,
  parameter int LONG_CYC  = 82000,
  parameter int PWRUP_CYC = 750000,
  parameter int CNT_W     = 20
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_io_lcd,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on,
  output logic [31:0] o_lcd_status
);

  localparam longint MAXV = (longint'(1) << CNT_W) - 1;

  if (SETUP_CYC < 1 || SETUP_CYC > MAXV || EN_CYC < 1 || EN_CYC > MAXV ||
      HOLD_CYC < 1 || HOLD_CYC > MAXV || EXEC_CYC < 1 || EXEC_CYC > MAXV ||
      LONG_CYC < 1 || LONG_CYC > MAXV || PWRUP_CYC < 1 || PWRUP_CYC > MAXV) begin : g_param_chk
    $error("lcd_ctrl: a *_CYC parameter does not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] L_SETUP = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] L_EN    = CNT_W'(EN_CYC - 1);
  localparam logic [CNT_W-1:0] L_HOLD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] L_EXEC  = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] L_LONG  = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] L_PWRUP = CNT_W'(PWRUP_CYC - 1);

  typedef enum logic [2:0] {
    S_PWRUP = 3'd0,
    S_IDLE  = 3'd1,
    S_SETUP = 3'd2,
    S_PULSE = 3'd3,
    S_HOLD  = 3'd4,
    S_EXEC  = 3'd5
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_timer;
  logic [CNT_W-1:0] w_lim;
  logic             w_last;
  logic [7:0]       r_data;
  logic             r_rs;
  logic             r_en;
  logic             r_on;
  logic             r_strobe_q;
  logic             r_pend_vld;
  logic             r_pend_rs;
  logic [7:0]       r_pend_byte;
  logic             r_overrun;
  logic             w_req;
  logic             w_long;
  logic             w_take_pend;
  logic             w_take_req;
  logic             w_pend_load;
  logic             w_drop;
  logic             w_unused;

  assign w_unused = ^{i_io_lcd[29:11], i_io_lcd[9]};

  // Edge-detect the strobe; strobe_q resets high so a strobe held through reset is not a request.
  assign w_req = i_io_lcd[8] & ~r_strobe_q;

  // Clear and return-home commands need the long execution wait.
  assign w_long = ~r_rs & ((r_data == 8'h01) | (r_data == 8'h02) | (r_data == 8'h03));

  always_comb begin
    w_lim = '0;
    case (r_state)
      S_PWRUP: w_lim = L_PWRUP;
      S_SETUP: w_lim = L_SETUP;
      S_PULSE: w_lim = L_EN;
      S_HOLD:  w_lim = L_HOLD;
      S_EXEC:  w_lim = w_long ? L_LONG : L_EXEC;
      default: w_lim = '0;
    endcase
  end

  assign w_last = (r_timer == w_lim);

  always_comb begin
    w_state_nxt = r_state;
    w_take_pend = 1'b0;
    w_take_req  = 1'b0;
    case (r_state)
      S_PWRUP: if (w_last) w_state_nxt = S_IDLE;
      S_IDLE: begin
        if (r_pend_vld) begin
          w_state_nxt = S_SETUP;
          w_take_pend = 1'b1;
        end else if (w_req) begin
          w_state_nxt = S_SETUP;
          w_take_req  = 1'b1;
        end
      end
      S_SETUP: if (w_last) w_state_nxt = S_PULSE;
      S_PULSE: if (w_last) w_state_nxt = S_HOLD;
      S_HOLD:  if (w_last) w_state_nxt = S_EXEC;
      S_EXEC: begin
        if (w_last) begin
          if (r_pend_vld) begin
            w_state_nxt = S_SETUP;
            w_take_pend = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_PWRUP;
    endcase
  end

  // A request that is not started directly goes to the buffer if it is free or being drained now.
  assign w_pend_load = w_req & ~w_take_req & (~r_pend_vld | w_take_pend);
  assign w_drop      = w_req & ~w_take_req & r_pend_vld & ~w_take_pend;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state     <= S_PWRUP;
      r_timer     <= '0;
      r_data      <= '0;
      r_rs        <= 1'b0;
      r_en        <= 1'b0;
      r_on        <= 1'b0;
      r_strobe_q  <= 1'b1;
      r_pend_vld  <= 1'b0;
      r_pend_rs   <= 1'b0;
      r_pend_byte <= '0;
      r_overrun   <= 1'b0;
    end else begin
      r_strobe_q <= i_io_lcd[8];
      r_on       <= i_io_lcd[31];
      r_state    <= w_state_nxt;
      r_en       <= (w_state_nxt == S_PULSE);

      if (w_state_nxt != r_state || w_state_nxt == S_IDLE) r_timer <= '0;
      else                                                 r_timer <= r_timer + 1'b1;

      if (w_take_pend) begin
        r_rs   <= r_pend_rs;
        r_data <= r_pend_byte;
      end else if (w_take_req) begin
        r_rs   <= i_io_lcd[10];
        r_data <= i_io_lcd[7:0];
      end

      r_pend_vld <= w_pend_load | (r_pend_vld & ~w_take_pend);
      if (w_pend_load) begin
        r_pend_rs   <= i_io_lcd[10];
        r_pend_byte <= i_io_lcd[7:0];
      end

      if (w_drop)            r_overrun <= 1'b1;
      else if (i_io_lcd[30]) r_overrun <= 1'b0;
    end
  end

  assign o_lcd_data   = r_data;
  assign o_lcd_rs     = r_rs;
  assign o_lcd_rw     = 1'b0;
  assign o_lcd_en     = r_en;
  assign o_lcd_on     = r_on;
  assign o_lcd_status = {29'b0, r_overrun, r_pend_vld, (r_state != S_IDLE)};

endmodule

// File: tb/tb_lcd_ctrl.sv
// Scoreboard bench for lcd_ctrl: a timeline model predicts each transfer's byte and start edge,
// and a negedge monitor checks every EN pulse against it.
module tb_lcd_ctrl;
  localparam int SU = 2, EN = 4, HO = 2, EX = 10, LG = 40, PU = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] io;
  logic [7:0]  o_lcd_data;
  logic        o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on;
  logic [31:0] o_lcd_status;

  lcd_ctrl #(.SETUP_CYC(SU), .EN_CYC(EN), .HOLD_CYC(HO), .EXEC_CYC(EX),
             .LONG_CYC(LG), .PWRUP_CYC(PU), .CNT_W(20)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_io_lcd(io),
    .o_lcd_data(o_lcd_data), .o_lcd_rs(o_lcd_rs), .o_lcd_rw(o_lcd_rw),
    .o_lcd_en(o_lcd_en), .o_lcd_on(o_lcd_on), .o_lcd_status(o_lcd_status));

  always #5 clk = ~clk;

  // cyc = number of rising edges so far; edge n is the one after which cyc reads n
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  typedef struct { bit rs; bit [7:0] b; int start; } xfer_t;
  xfer_t exp_q[$];
  int pwrup_end, last_start, last_end, prev_end;
  bit ovr_m, abort;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int dur(bit rs, bit [7:0] b);
    return SU + EN + HO + ((!rs && b >= 8'h01 && b <= 8'h03) ? LG : EX);
  endfunction

  function automatic void model_reset(int r);
    pwrup_end  = r + PU;
    last_start = -1;
    last_end   = pwrup_end;
    prev_end   = pwrup_end;
    ovr_m      = 1'b0;
    exp_q.delete();
  endfunction

  // Request sampled at edge n: start now, wait behind the running transfer, or be dropped.
  function automatic void model_req(int n, bit rs, bit [7:0] b);
    int s;
    xfer_t x;
    if (last_start > n) begin
      ovr_m = 1'b1;
      return;
    end
    if (n > last_end)                                  s = n;
    else if (last_start < 0 && last_end == pwrup_end)  s = pwrup_end + 1;
    else                                               s = (n + 1 > last_end) ? n + 1 : last_end;
    prev_end   = last_end;
    last_start = s;
    last_end   = s + dur(rs, b);
    x.rs = rs; x.b = b; x.start = s;
    exp_q.push_back(x);
  endfunction

  function automatic logic [2:0] model_status(int n);
    bit busy, pend;
    pend = (last_start > n);
    busy = (n < pwrup_end) || ((last_start <= n) ? (n < last_end) : (n < prev_end));
    return {ovr_m, pend, busy};
  endfunction

  // Monitor: every EN rising edge is a transfer; pop and compare it.
  int en_w = 0;
  bit en_q = 1'b0;
  xfer_t mx;
  always @(negedge clk) begin
    if (o_lcd_en && !en_q) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_xfer: got data 0x%0h rs %0d expected no transfer", o_lcd_data, o_lcd_rs);
      end else begin
        mx = exp_q.pop_front();
        chk("xfer_data", o_lcd_data, mx.b);
        chk("xfer_rs", o_lcd_rs, mx.rs);
        chk("en_rise_edge", cyc, mx.start + SU);
      end
      chk("rw", o_lcd_rw, 0);
      en_w = 1;
    end else if (o_lcd_en) begin
      en_w++;
    end else if (en_q && !abort) begin
      chk("en_width", en_w, EN);
    end
    en_q = o_lcd_en;
  end

  task automatic send(bit rs, bit [7:0] b);
    @(negedge clk);
    io[10] = rs; io[7:0] = b; io[8] = 1'b1;
    model_req(cyc + 1, rs, b);
    @(negedge clk);
    io[8] = 1'b0;
    chk("status_after_req", o_lcd_status, {29'b0, model_status(cyc)});
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!(exp_q.size() == 0 && cyc > last_end + 1) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("drain_in_time", k < 3000, 1);
  endtask

  task automatic wait_en();
    int k = 0;
    while (!o_lcd_en && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("en_seen", o_lcd_en, 1);
  endtask

  task automatic busy_len(output int len);
    len = 0;
    while (o_lcd_status[0] && len < 500) begin
      len++;
      @(negedge clk);
    end
  endtask

  initial begin
    int len;
    bit rs;
    bit [7:0] b;
    rst_n = 1'b0;
    io    = 32'h0000_0100;
    abort = 1'b0;
    model_reset(0);

    // reset held with strobe high: no transfer, busy through power-up only
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    model_reset(cyc);
    for (int i = 0; i <= PU; i++) begin
      chk("pwrup_status", o_lcd_status, (i < PU) ? 1 : 0);
      chk("pwrup_outputs", {o_lcd_data, o_lcd_rs, o_lcd_en, o_lcd_on, o_lcd_rw}, 0);
      @(negedge clk);
    end
    io[8] = 1'b0;

    io[31] = 1'b1;
    @(negedge clk);
    chk("lcd_on_set", o_lcd_on, 1);
    io[31] = 1'b0;
    @(negedge clk);
    chk("lcd_on_clr", o_lcd_on, 0);

    // single write
    send(1'b1, 8'h41);
    chk("single_data", o_lcd_data, 8'h41);
    chk("single_rs", o_lcd_rs, 1);
    busy_len(len);
    chk("single_busy_len", len, 18);
    wait_idle();
    chk("idle_hold_data", {o_lcd_rs, o_lcd_data}, {1'b1, 8'h41});

    // long and normal command waits
    send(1'b0, 8'h01);
    busy_len(len);
    chk("clear_busy_len", len, 48);
    wait_idle();
    send(1'b0, 8'h38);
    busy_len(len);
    chk("func_busy_len", len, 18);
    wait_idle();

    // second request during EN pulse is buffered and follows with no idle gap
    send(1'b0, 8'h38);
    wait_en();
    send(1'b1, 8'h42);
    chk("buffer_status", o_lcd_status, 3);
    wait_idle();

    // third request while buffer full is dropped; clear pulse drops the flag
    send(1'b1, 8'h61);
    send(1'b1, 8'h62);
    send(1'b1, 8'h63);
    chk("overrun_status", o_lcd_status, 7);
    @(negedge clk);
    io[30] = 1'b1;
    @(negedge clk);
    io[30] = 1'b0;
    ovr_m = 1'b0;
    chk("overrun_cleared", o_lcd_status[2], 0);
    wait_idle();

    // randomized requests with random spacing
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 25)) @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk);
        io[30] = 1'b1;
        @(negedge clk);
        io[30] = 1'b0;
        ovr_m = 1'b0;
        chk("rand_ovr_clear", o_lcd_status[2], 0);
      end
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       b = 8'h01;
        1:       b = 8'($urandom_range(2, 3));
        default: b = 8'($urandom_range(0, 255));
      endcase
      send(rs, b);
    end
    wait_idle();
    chk("rand_final_status", o_lcd_status, {29'b0, model_status(cyc)});

    // reset during EN pulse aborts the transfer and loses the buffered one
    send(1'b1, 8'h55);
    send(1'b1, 8'h56);
    wait_en();
    abort = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_en_low", o_lcd_en, 0);
    chk("abort_status", o_lcd_status, 1);
    rst_n = 1'b1;
    model_reset(cyc);
    repeat (PU + 30) @(negedge clk);
    abort = 1'b0;
    chk("post_abort_status", o_lcd_status, 0);
    chk("post_abort_no_xfer", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
